// File: rtl/muldiv_if.sv
// Handshake and result bus between the EX stage and the iterative mul/div unit.
interface muldiv_if #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start_i;
    logic [2:0]                op_i;
    logic [WIDTH-1:0]          a_i;
    logic [WIDTH-1:0]          b_i;
    logic [REG_ADDR_WIDTH-1:0] rd_i;
    logic                      kill_i;
    logic                      busy_o;
    logic                      done_o;
    logic [WIDTH-1:0]          result_o;
    logic [REG_ADDR_WIDTH-1:0] rd_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_i, kill_i,
        input  busy_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_i, kill_i,
        output busy_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a start pulse
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | apply result sign, select half/quotient/remainder, register
// DONE  | done_o pulse; a new start may be accepted here
module muldiv_sequencer #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  md
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      sign_q, sign_d;
    logic [WIDTH-1:0]          opnd_q, opnd_d;
    // MUL: {partial high, multiplier shifting out}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]          result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;
    logic                      busy;

    // Operand decode at acceptance: which operands are signed, magnitudes, sign of result
    logic             signed_a, signed_b, a_neg, b_neg, res_sign;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, fast, accept;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        signed_a = (md.op_i != 3'b011) && (md.op_i != 3'b101) && (md.op_i != 3'b111);
        signed_b = (md.op_i == 3'b000) || (md.op_i == 3'b001) ||
                   (md.op_i == 3'b100) || (md.op_i == 3'b110);
        a_neg    = signed_a && md.a_i[WIDTH-1];
        b_neg    = signed_b && md.b_i[WIDTH-1];
        a_mag    = a_neg ? (~md.a_i + 1'b1) : md.a_i;
        b_mag    = b_neg ? (~md.b_i + 1'b1) : md.b_i;
        // REM/REMU take the dividend sign; REMU never has a negative dividend
        res_sign = (md.op_i[2] && md.op_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = (md.b_i == '0);
        div_ovf  = !md.op_i[0] && (md.a_i == MIN_NEG) && (md.b_i == '1);
        fast     = md.op_i[2] && (div_zero || div_ovf);
        if (div_zero)
            fast_res = md.op_i[1] ? md.a_i : '1;
        else
            fast_res = md.op_i[1] ? '0 : MIN_NEG;
        accept   = md.start_i && !md.kill_i && (state_q == S_IDLE || state_q == S_DONE);
    end

    // One iteration step of each datapath
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // borrow out of the trial subtract means the shifted remainder was below the divisor
        div_ge    = !div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Sign fix-up and result selection for the FIX state
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = sign_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = sign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = sign_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 fix_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // Next-state and datapath updates; kill overrides everything and freezes the result
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sign_d   = sign_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        busy     = 1'b0;
        if (md.kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        busy   = 1'b1;
                        op_d   = md.op_i;
                        rd_d   = md.rd_i;
                        sign_d = res_sign;
                        cnt_d  = '0;
                        if (fast) begin
                            result_d = fast_res;
                            rd_out_d = md.rd_i;
                            state_d  = S_DONE;
                        end else if (md.op_i[2]) begin
                            opnd_d  = b_mag;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            state_d = S_DIV;
                        end else begin
                            opnd_d  = a_mag;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    busy  = 1'b1;
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    busy     = 1'b1;
                    result_d = fix_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sign_q   <= sign_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign md.busy_o   = busy;
    assign md.done_o   = (state_q == S_DONE);
    assign md.result_o = result_q;
    assign md.rd_o     = rd_out_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios plus randomized ops, all
// checked every cycle against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W  = 32;
    localparam int RW = 5;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;

    muldiv_if #(.WIDTH(W), .REG_ADDR_WIDTH(RW)) md ();

    muldiv_sequencer #(.WIDTH(W), .REG_ADDR_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from the RV32M definitions
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return W + 2;
    endfunction

    // Cycle-level model: one outstanding op with a known completion cycle
    bit          armed    = 1'b0;
    bit          inflight = 1'b0;
    int          done_at  = 0;
    logic [31:0] pend_res, res_m;
    logic [4:0]  pend_rd, rd_m;

    always @(negedge clk) begin
        bit exp_done, exp_acc, exp_busy;
        if (armed) begin
            exp_done = inflight && (done_at == cyc);
            exp_acc  = md.start_i && !md.kill_i && (!inflight || exp_done);
            exp_busy = exp_acc || (inflight && cyc < done_at && !md.kill_i);
            if (exp_done) begin
                res_m = pend_res;
                rd_m  = pend_rd;
            end
            chk("busy_o",   32'(md.busy_o), 32'(exp_busy));
            chk("done_o",   32'(md.done_o), 32'(exp_done));
            chk("result_o", md.result_o, res_m);
            chk("rd_o",     32'(md.rd_o), 32'(rd_m));
            if (md.start_i && inflight && !exp_done && !md.kill_i && !rst) begin
                n_fail++;
                $display("FAIL protocol: start_i while busy at cycle %0d", cyc);
            end
            if (rst) begin
                inflight = 1'b0;
                res_m    = '0;
                rd_m     = '0;
            end else if (md.kill_i) begin
                inflight = 1'b0;
            end else if (exp_acc) begin
                inflight = 1'b1;
                done_at  = cyc + latency(md.op_i, md.a_i, md.b_i);
                pend_res = ref_result(md.op_i, md.a_i, md.b_i);
                pend_rd  = md.rd_i;
            end else if (exp_done) begin
                inflight = 1'b0;
            end
        end else if (rst) begin
            armed    = 1'b1;
            inflight = 1'b0;
            res_m    = '0;
            rd_m     = '0;
        end
    end

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        md.start_i = 1'b1;
        md.op_i    = op;
        md.a_i     = a;
        md.b_i     = b;
        md.rd_i    = rd;
    endtask

    task automatic drop_start();
        md.start_i = 1'b0;
        md.a_i     = $urandom;
        md.b_i     = $urandom;
        md.op_i    = 3'($urandom_range(0, 7));
    endtask

    // Wait (bounded) for done_o, then check latency from start cycle c0 and the result
    task automatic wait_check(input string name, input int c0, input int exp_lat,
                              input logic [31:0] exp_res, input logic [4:0] exp_rd);
        int k;
        k = 0;
        while (k < 45) begin
            @(negedge clk);
            if (md.done_o === 1'b1) break;
            k++;
        end
        chk({name, " latency"}, 32'(cyc - c0), 32'(exp_lat));
        chk({name, " result"}, md.result_o, exp_res);
        chk({name, " rd"}, 32'(md.rd_o), 32'(exp_rd));
        @(posedge clk);
        #1;
    endtask

    task automatic run_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                           input logic [31:0] exp_res);
        int c0;
        c0 = cyc;
        drive_start(op, a, b, rd);
        @(posedge clk);
        #1 drop_start();
        wait_check(name, c0, exp_lat, exp_res, rd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, lat, k;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst = 1'b1;
        md.start_i = 1'b0; md.kill_i = 1'b0; md.op_i = '0;
        md.a_i = '0; md.b_i = '0; md.rd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset result_o", md.result_o, 32'h0);
        chk("reset busy_o", 32'(md.busy_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pin the reference model to hand-computed values
        chk("model MUL",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model MULHSU", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        chk("model DIV",    ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model REM",    ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        // Directed arithmetic and fast-path cases
        run_lit("MUL 7x-3",     3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, 32'hFFFF_FFEB);
        run_lit("MULH min^2",   3'd1, MINV, MINV, 5'd1, 34, 32'h4000_0000);
        run_lit("MULHU max^2",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 34, 32'hFFFF_FFFE);
        run_lit("MULHSU -1x2",  3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 34, 32'hFFFF_FFFF);
        run_lit("DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 34, 32'hFFFF_FFFD);
        run_lit("REM -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 34, 32'hFFFF_FFFF);
        run_lit("DIVU 100/7",   3'd5, 32'd100, 32'd7, 5'd7, 34, 32'd14);
        run_lit("REMU 100/7",   3'd7, 32'd100, 32'd7, 5'd8, 34, 32'd2);
        run_lit("DIVU 5/0",     3'd5, 32'd5, 32'd0, 5'd9, 1, 32'hFFFF_FFFF);
        run_lit("REM 5/0",      3'd6, 32'd5, 32'd0, 5'd10, 1, 32'd5);
        run_lit("DIV ovf",      3'd4, MINV, 32'hFFFF_FFFF, 5'd11, 1, MINV);
        run_lit("REM ovf",      3'd6, MINV, 32'hFFFF_FFFF, 5'd12, 1, 32'd0);

        // Kill at cycle 10 of a DIV, then a fresh MUL at cycle 12
        c0 = cyc;
        drive_start(3'd5, 32'd1000, 32'd7, 5'd13);
        @(posedge clk);
        #1 drop_start();
        repeat (9) @(posedge clk);
        #1 md.kill_i = 1'b1;
        @(negedge clk);
        chk("kill busy_o", 32'(md.busy_o), 32'h0);
        chk("kill cycle", 32'(cyc - c0), 32'd10);
        @(posedge clk);
        #1 md.kill_i = 1'b0;
        @(negedge clk);
        chk("post-kill done_o", 32'(md.done_o), 32'h0);
        @(posedge clk);
        #1;
        run_lit("MUL 3x4 after kill", 3'd0, 32'd3, 32'd4, 5'd14, 34, 32'd12);

        // Reset at cycle 20 of a MUL
        drive_start(3'd0, 32'd5, 32'd6, 5'd15);
        @(posedge clk);
        #1 drop_start();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst busy_o",   32'(md.busy_o), 32'h0);
        chk("post-rst done_o",   32'(md.done_o), 32'h0);
        chk("post-rst result_o", md.result_o, 32'h0);
        chk("post-rst rd_o",     32'(md.rd_o), 32'h0);
        repeat (40) @(posedge clk);
        #1;

        // Back-to-back: second start in the DONE cycle of the first
        c0 = cyc;
        drive_start(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        @(posedge clk);
        #1 drop_start();
        repeat (33) @(posedge clk);
        #1 drive_start(3'd7, 32'd100, 32'd7, 5'd11);
        @(negedge clk);
        chk("b2b first done_o", 32'(md.done_o), 32'h1);
        chk("b2b first rd_o", 32'(md.rd_o), 32'd10);
        chk("b2b first result", md.result_o, 32'hFFFF_FFFE);
        chk("b2b busy_o", 32'(md.busy_o), 32'h1);
        @(posedge clk);
        #1 drop_start();
        wait_check("b2b second", c0 + 34, 34, 32'd2, 5'd11);

        // Randomized ops with back-to-back starts, gaps and kills
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 60);
                    b = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: begin a = $urandom; b = $urandom_range(1, 5); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            rd  = 5'($urandom);
            lat = latency(op, a, b);
            drive_start(op, a, b, rd);
            @(posedge clk);
            #1 drop_start();
            if (lat > 1 && $urandom_range(0, 5) == 0) begin
                k = $urandom_range(1, 32);
                repeat (k - 1) @(posedge clk);
                #1 md.kill_i = 1'b1;
                if ($urandom_range(0, 1) == 1) drive_start(3'd0, 32'd9, 32'd9, 5'd31);
                @(posedge clk);
                #1 md.kill_i = 1'b0;
                drop_start();
            end else begin
                repeat (lat - 1) @(posedge clk);
                #1;
                if ($urandom_range(0, 2) != 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end

        repeat (40) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
